// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between an instruction-fetch port
// and a data port. Each access takes four cycles:
//   IDLE -> ACC -> RESP -> DONE -> IDLE
// The winning request is latched on the edge leaving IDLE. The address is
// driven in ACC and held through RESP. Read data is captured at the end of
// RESP. The granted port sees a one-cycle done pulse in DONE.
//
// Parameters
//   ADDR_W   RAM word-address width. Address bits above this are ignored.
//   DATA_W   data width.
//
// Ports
//   clk, rst            single clock; asynchronous active-high reset
//   if_req, if_addr     fetch request (held until if_done) and its address
//   if_done, if_rdata   fetch completion pulse and registered fetched word
//   d_req, d_we,        data request, write enable, address and write data,
//   d_addr, d_wdata     all held until d_done
//   d_done, d_rdata     data completion pulse and registered read word
//   ram_addr, ram_din,  RAM address, write data and write enable
//   ram_we
//   ram_dout            RAM read data, valid one cycle after the address
//   busy                high whenever an access is in progress
//
// Configuration
//   MEM_ARBITER_RR_EN   defined   : round-robin on ties. The port that was
//                                   not granted last wins. The last-grant
//                                   register updates on every grant.
//                       undefined : fixed priority. The data port always
//                                   wins ties.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic                gnt_data_q, gnt_data_d;   // 1 = data port owns the access
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic                we_q,       we_d;         // only ever set for a data write
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;

    logic                pick_data;                // arbitration result in IDLE

    // The upper address bits are intentionally dropped (the address wraps
    // modulo 2^ADDR_W). They are reduced into a named sink so that they are
    // visibly consumed.
    logic unused_addr_hi;
    if (ADDR_W < 32) begin : g_addr_hi
        assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};
    end else begin : g_no_addr_hi
        assign unused_addr_hi = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef MEM_ARBITER_RR_EN
    logic last_data_q, last_data_d;                // 1 = data was granted last

    // On a tie, the port that was not granted last wins. A single request
    // always wins.
    assign pick_data = d_req & (~if_req | ~last_data_q);
`else
    // Fixed priority: the data port wins every tie.
    assign pick_data = d_req;
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever order these
    // statements are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the read-data registers and the latched request are reset
            // along with the state. Their values are visible on the ports
            // immediately after reset, so they must be defined then.
            state_q    <= IDLE;
            gnt_data_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in this block gets a default first.
        // No path through the case can then leave a signal unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARBITER_RR_EN
        last_data_d = last_data_q;
`endif

        ram_addr = addr_q;
        ram_din  = wdata_q;
        ram_we   = 1'b0;
        if_done  = 1'b0;
        d_done   = 1'b0;
        busy     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Requests are sampled only here. The winner's address,
                // direction and data are frozen for the whole access.
                if (if_req || d_req) begin
                    state_d    = ACC;
                    gnt_data_d = pick_data;
                    addr_d     = pick_data ? d_addr[ADDR_W-1:0]
                                           : if_addr[ADDR_W-1:0];
                    we_d       = pick_data & d_we;
                    wdata_d    = (pick_data & d_we) ? d_wdata : '0;
`ifdef MEM_ARBITER_RR_EN
                    last_data_d = pick_data;
`endif
                end
            end

            ACC: begin
                // The RAM samples the address (and any write) at the end of
                // this cycle.
                ram_we  = we_q;
                state_d = RESP;
            end

            RESP: begin
                // ram_dout now holds the word addressed in ACC. Only a read
                // loads the granted port's register. A write leaves both
                // read-data registers untouched.
                state_d = DONE;
                if (!we_q) begin
                    if (gnt_data_q) begin
                        d_rdata_d = ram_dout;
                    end else begin
                        if_rdata_d = ram_dout;
                    end
                end
            end

            DONE: begin
                if_done = ~gnt_data_q;
                d_done  =  gnt_data_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
